// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_ripple_adder
// Brief    : WIDTH-bit add/subtract, one CHUNK-bit ripple slice per stage,
//            valid/ready handshake with bubble-collapsing stage registers.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_ripple_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // r_acc: chunks below the stage hold finished sum bits, chunks above hold
    // operand A still waiting for its slice.
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_acc [STAGES];
    logic [WIDTH-1:0] r_opb [STAGES];
    logic             r_cy  [STAGES];
    logic             r_ovf;

    logic             w_load    [STAGES];
    logic             w_src_vld [STAGES];
    logic [WIDTH-1:0] w_src_acc [STAGES];
    logic [WIDTH-1:0] w_src_opb [STAGES];
    logic             w_src_cy  [STAGES];
    logic [WIDTH-1:0] w_nxt_acc [STAGES];
    logic             w_nxt_cy  [STAGES];
    logic             w_nxt_ovf;

    // A stage loads when empty or when its occupant moves on this cycle.
    always_comb begin : p_flow
        logic w_take;
        w_take = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_take    = !r_vld[i] || w_take;
            w_load[i] = w_take;
        end
    end

    always_comb begin : p_src
        w_src_vld[0] = in_valid;
        w_src_acc[0] = a;
        w_src_opb[0] = sub ? ~b : b;
        w_src_cy[0]  = sub | ci;
        for (int i = 1; i < STAGES; i++) begin
            w_src_vld[i] = r_vld[i-1];
            w_src_acc[i] = r_acc[i-1];
            w_src_opb[i] = r_opb[i-1];
            w_src_cy[i]  = r_cy[i-1];
        end
    end

    always_comb begin : p_add
        logic [CHUNK:0] w_part;
        w_part    = '0;
        w_nxt_ovf = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            w_part = {1'b0, w_src_acc[i][i*CHUNK +: CHUNK]}
                   + {1'b0, w_src_opb[i][i*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_src_cy[i]};
            w_nxt_acc[i]                 = w_src_acc[i];
            w_nxt_acc[i][i*CHUNK +: CHUNK] = w_part[CHUNK-1:0];
            w_nxt_cy[i]                  = w_part[CHUNK];
            if (i == STAGES - 1) begin
                w_nxt_ovf = (w_src_acc[i][WIDTH-1] == w_src_opb[i][WIDTH-1])
                         && (w_part[CHUNK-1] != w_src_acc[i][WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_acc[i] <= '0;
                r_opb[i] <= '0;
                r_cy[i]  <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= w_src_vld[i];
                    if (w_src_vld[i]) begin
                        r_acc[i] <= w_nxt_acc[i];
                        r_opb[i] <= w_src_opb[i];
                        r_cy[i]  <= w_nxt_cy[i];
                    end
                end
            end
            if (w_load[STAGES-1] && w_src_vld[STAGES-1]) begin
                r_ovf <= w_nxt_ovf;
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_acc[STAGES-1];
    assign co        = r_cy[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_ripple_adder
// Brief    : Self-checking bench for pipelined_ripple_adder (32-bit, 8-bit slices)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_ripple_adder;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             ci        = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    pipelined_ripple_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int          n_cmp   = 0;
    int          n_mis   = 0;
    int          n_acc   = 0;
    int          n_emit  = 0;
    logic [33:0] q [$];
    logic [33:0] cur_exp = '0;

    // Expected {co, ovf, sum} from plain wide arithmetic.
    function automatic logic [33:0] ref_model(input logic [31:0] av, input logic [31:0] bv,
                                              input logic civ, input logic subv);
        longint ua, ub, sa, sb, ures, sres;
        logic   c, o;
        ua = {32'd0, av};
        ub = {32'd0, bv};
        sa = $signed(av);
        sb = $signed(bv);
        if (subv) begin
            ures = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + longint'(civ);
            c    = (ures >= 64'sh1_0000_0000);
            sres = sa + sb + longint'(civ);
        end
        o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {c, o, ures[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Book-keep the handshakes seen before the coming edge, then advance one cycle.
    task automatic tick();
        logic [33:0] w_exp;
        if (in_valid && in_ready) begin
            q.push_back(cur_exp);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_emit++;
            n_cmp++;
            assert (q.size() > 0) else begin
                n_mis++;
                $error("FAIL unexpected_result: observed %0h expected no result", {co, ovf, sum});
            end
            if (q.size() > 0) begin
                w_exp = q.pop_front();
                chk("result", {30'd0, co, ovf, sum}, {30'd0, w_exp});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [31:0] av, input logic [31:0] bv, input logic civ,
                            input logic subv, input logic [33:0] exp);
        a = av; b = bv; ci = civ; sub = subv;
        cur_exp = exp;
    endtask

    task automatic rand_beat();
        a   = $urandom;
        b   = $urandom;
        ci  = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0:       b = a;
            1:       a = 32'hFFFF_FFFF;
            2:       b = 32'h8000_0000;
            default: ;
        endcase
        cur_exp = ref_model(a, b, ci, sub);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < budget && q.size() > 0; k++) begin
            settle();
            tick();
        end
        chk("drain_empty", q.size(), 0);
        for (int k = 0; k < 6; k++) begin
            settle();
            tick();
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   acc_cnt;
        int   emit0;
        int   acc0;
        logic took;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("in_ready_after_rst", in_ready, 1);
        tick();

        // Carry through every slice, exact latency of 4 edges
        out_ready = 1'b1;
        set_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
        in_valid = 1'b1;
        settle();
        chk("lat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            settle();
            chk("lat_early", out_valid, 0);
            tick();
        end
        settle();
        chk("lat_at_4", out_valid, 1);
        tick();
        drain(8);

        // Signed overflow, borrow, and ci ignored on subtract
        in_valid = 1'b1;
        set_beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
        settle(); tick();
        set_beat(32'h5, 32'h7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        settle(); tick();
        set_beat(32'h5, 32'h7, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        settle(); tick();
        set_beat(32'hA, 32'h3, 1'b0, 1'b1, {1'b1, 1'b0, 32'h0000_0007});
        settle(); tick();
        drain(10);

        // 100 back-to-back beats, one result per cycle
        out_ready = 1'b1;
        for (int k = 0; k < 104; k++) begin
            if (k < 100) begin
                rand_beat();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            settle();
            if (k < 100) chk("b2b_in_ready", in_ready, 1);
            if (k >= 4)  chk("b2b_out_valid", out_valid, 1);
            tick();
        end
        drain(8);

        // Backpressure: 6 beats offered, only 4 fit, outputs frozen
        out_ready = 1'b0;
        acc_cnt   = 0;
        emit0     = n_emit;
        took      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                if (took) rand_beat();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            settle();
            if (k >= 4) begin
                chk("full_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_hold_data", {30'd0, co, ovf, sum}, {30'd0, q[0]});
            end
            took = in_valid && in_ready;
            if (took) acc_cnt++;
            tick();
        end
        chk("stall_accepted", acc_cnt, 4);
        drain(10);
        chk("stall_drained", n_emit - emit0, 4);

        // Random valid/ready toggling
        emit0 = n_emit;
        acc0  = n_acc;
        for (int k = 0; k < 10000; k++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            settle();
            tick();
        end
        drain(50);
        chk("rand_conserved", n_emit - emit0, n_acc - acc0);

        // Reset with 3 beats in flight, one already presented at the output
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_beat();
            in_valid = 1'b1;
            settle();
            chk("pre_rst_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        settle();
        tick();
        settle();
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_co", co, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("post_rst_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        emit0     = n_emit;
        for (int k = 0; k < 2; k++) begin
            rand_beat();
            in_valid = 1'b1;
            settle();
            tick();
        end
        drain(10);
        chk("post_rst_results", n_emit - emit0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
